// File: rtl/ux607_i2c_master_txn_seq.sv
`default_nettype none
// ============================================================================
// Module   : ux607_i2c_master_txn_seq
// Purpose  : I2C master transaction sequencer. Turns one register-oriented
//            request (device address, register address, read/write, 0..15
//            data bytes) into the command sequence for a byte-level I2C
//            controller: START+device, register byte, write data (with STOP
//            on the last byte) or repeated START and read data (NACK+STOP on
//            the last byte). Handles slave NACK and arbitration loss.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option : UX607_I2C_SEQ_NOREG_EN adds i_req_noreg. When set with a
//                request, the register-address phase is skipped (writes go
//                DEV -> data, reads start directly with START + {dev,1}).
// ----------------------------------------------------------------------------
// Ports
//   clk, rst (async, active-high)
//   i_req_valid / o_req_ready      request handshake
//   i_req_dev[6:0], i_req_rnw, i_req_reg[7:0], i_req_len[3:0]
//   i_req_noreg                    (only with UX607_I2C_SEQ_NOREG_EN)
//   i_wdata_valid / o_wdata_ready, i_wdata[7:0]   write-data stream
//   o_rdata_valid / i_rdata_ready, o_rdata[7:0]   read-data stream
//   o_done (1-cycle pulse), o_nack, o_al_err (valid with o_done)
//   o_bc_start/stop/read/write/ack_in, o_bc_din[7:0]  byte-controller cmds
//   i_bc_cmd_ack, i_bc_ack_out, i_bc_al, i_bc_dout[7:0] byte-controller status
// All outputs are driven directly from registers.
// ============================================================================
module ux607_i2c_master_txn_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [6:0] i_req_dev,
  input  logic       i_req_rnw,
  input  logic [7:0] i_req_reg,
  input  logic [3:0] i_req_len,
`ifdef UX607_I2C_SEQ_NOREG_EN
  input  logic       i_req_noreg,
`endif
  input  logic       i_wdata_valid,
  output logic       o_wdata_ready,
  input  logic [7:0] i_wdata,
  output logic       o_rdata_valid,
  input  logic       i_rdata_ready,
  output logic [7:0] o_rdata,
  output logic       o_done,
  output logic       o_nack,
  output logic       o_al_err,
  output logic       o_bc_start,
  output logic       o_bc_stop,
  output logic       o_bc_read,
  output logic       o_bc_write,
  output logic       o_bc_ack_in,
  output logic [7:0] o_bc_din,
  input  logic       i_bc_cmd_ack,
  input  logic       i_bc_ack_out,
  input  logic       i_bc_al,
  input  logic [7:0] i_bc_dout
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_DEV   = 4'd1,
    S_REG   = 4'd2,
    S_WDAT  = 4'd3,
    S_RSTRT = 4'd4,
    S_RDAT  = 4'd5,
    S_RHOLD = 4'd6,
    S_STOP  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  // Command vector bit order: {start, stop, read, write, ack_in}
  localparam logic [4:0] c_CMD_NONE     = 5'b00000;
  localparam logic [4:0] c_CMD_START_WR = 5'b10010;
  localparam logic [4:0] c_CMD_WR       = 5'b00010;
  localparam logic [4:0] c_CMD_WR_STOP  = 5'b01010;
  localparam logic [4:0] c_CMD_RD       = 5'b00100;
  localparam logic [4:0] c_CMD_RD_LAST  = 5'b01101;
  localparam logic [4:0] c_CMD_STOP     = 5'b01000;

  // State and latched request
  state_t     r_state, w_state_nxt;
  logic [6:0] r_dev,   w_dev_nxt;
  logic       r_rnw,   w_rnw_nxt;
  logic [7:0] r_reg,   w_reg_nxt;
  logic [3:0] r_len,   w_len_nxt;
  logic [3:0] r_cnt,   w_cnt_nxt;
  logic       r_noreg, w_noreg_nxt;

  // Output registers
  logic       r_req_ready,   w_req_ready_nxt;
  logic       r_wdata_ready, w_wdata_ready_nxt;
  logic       r_rdata_valid, w_rdata_valid_nxt;
  logic [7:0] r_rdata,       w_rdata_nxt;
  logic       r_done,        w_done_nxt;
  logic       r_nack,        w_nack_nxt;
  logic       r_al_err,      w_al_err_nxt;
  logic [4:0] r_cmd,         w_cmd_nxt;
  logic [7:0] r_din,         w_din_nxt;

  logic       w_noreg_in;
  logic       w_last;
  logic       w_last_inc;
  logic [3:0] w_cnt_inc;

`ifdef UX607_I2C_SEQ_NOREG_EN
  assign w_noreg_in = i_req_noreg;
`else
  assign w_noreg_in = 1'b0;
`endif

  // "Last byte" for the byte in flight, and for the byte after it (used when
  // RHOLD issues the next read in the same cycle it advances the counter).
  assign w_cnt_inc  = r_cnt + 4'd1;
  assign w_last     = (r_cnt == (r_len - 4'd1));
  assign w_last_inc = (w_cnt_inc == (r_len - 4'd1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_dev         <= 7'd0;
      r_rnw         <= 1'b0;
      r_reg         <= 8'd0;
      r_len         <= 4'd0;
      r_cnt         <= 4'd0;
      r_noreg       <= 1'b0;
      r_req_ready   <= 1'b0;
      r_wdata_ready <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_rdata       <= 8'd0;
      r_done        <= 1'b0;
      r_nack        <= 1'b0;
      r_al_err      <= 1'b0;
      r_cmd         <= c_CMD_NONE;
      r_din         <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_dev         <= w_dev_nxt;
      r_rnw         <= w_rnw_nxt;
      r_reg         <= w_reg_nxt;
      r_len         <= w_len_nxt;
      r_cnt         <= w_cnt_nxt;
      r_noreg       <= w_noreg_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_wdata_ready <= w_wdata_ready_nxt;
      r_rdata_valid <= w_rdata_valid_nxt;
      r_rdata       <= w_rdata_nxt;
      r_done        <= w_done_nxt;
      r_nack        <= w_nack_nxt;
      r_al_err      <= w_al_err_nxt;
      r_cmd         <= w_cmd_nxt;
      r_din         <= w_din_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and next registered outputs. Outputs are computed for the
  // state being entered, so a command is visible on the bus in the first
  // cycle of its state and holds until the controller acknowledges it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_dev_nxt         = r_dev;
    w_rnw_nxt         = r_rnw;
    w_reg_nxt         = r_reg;
    w_len_nxt         = r_len;
    w_cnt_nxt         = r_cnt;
    w_noreg_nxt       = r_noreg;
    w_wdata_ready_nxt = r_wdata_ready;
    w_rdata_valid_nxt = r_rdata_valid;
    w_rdata_nxt       = r_rdata;
    w_done_nxt        = 1'b0;
    w_nack_nxt        = r_nack;
    w_al_err_nxt      = r_al_err;
    w_cmd_nxt         = r_cmd;
    w_din_nxt         = r_din;

    // Arbitration loss wins over everything, including a same-cycle ack.
    // The bus is no longer ours, so no STOP is attempted. DONE is excluded:
    // the transaction has already reported its end.
    if (i_bc_al && (r_state != S_IDLE) && (r_state != S_DONE)) begin
      w_cmd_nxt         = c_CMD_NONE;
      w_wdata_ready_nxt = 1'b0;
      w_rdata_valid_nxt = 1'b0;
      w_al_err_nxt      = 1'b1;
      w_done_nxt        = 1'b1;
      w_state_nxt       = S_DONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid && r_req_ready) begin
            w_dev_nxt    = i_req_dev;
            w_rnw_nxt    = i_req_rnw;
            w_reg_nxt    = i_req_reg;
            w_len_nxt    = i_req_len;
            w_noreg_nxt  = w_noreg_in;
            w_cnt_nxt    = 4'd0;
            w_nack_nxt   = 1'b0;
            w_al_err_nxt = 1'b0;
            w_cmd_nxt    = c_CMD_START_WR;
            if (w_noreg_in && i_req_rnw) begin
              // Register-less read: go straight to START + read address
              w_din_nxt   = {i_req_dev, 1'b1};
              w_state_nxt = S_RSTRT;
            end else begin
              w_din_nxt   = {i_req_dev, 1'b0};
              w_state_nxt = S_DEV;
            end
          end
        end

        S_DEV: begin
          if (i_bc_cmd_ack) begin
            if (i_bc_ack_out) begin
              w_nack_nxt  = 1'b1;
              w_cmd_nxt   = c_CMD_STOP;
              w_state_nxt = S_STOP;
            end else if (r_noreg) begin
              if (r_len == 4'd0) begin
                w_cmd_nxt   = c_CMD_STOP;
                w_state_nxt = S_STOP;
              end else begin
                w_cmd_nxt         = c_CMD_NONE;
                w_wdata_ready_nxt = 1'b1;
                w_state_nxt       = S_WDAT;
              end
            end else begin
              w_cmd_nxt   = c_CMD_WR;
              w_din_nxt   = r_reg;
              w_state_nxt = S_REG;
            end
          end
        end

        S_REG: begin
          if (i_bc_cmd_ack) begin
            if (i_bc_ack_out) begin
              w_nack_nxt  = 1'b1;
              w_cmd_nxt   = c_CMD_STOP;
              w_state_nxt = S_STOP;
            end else if (r_rnw) begin
              w_cmd_nxt   = c_CMD_START_WR;
              w_din_nxt   = {r_dev, 1'b1};
              w_state_nxt = S_RSTRT;
            end else if (r_len == 4'd0) begin
              w_cmd_nxt   = c_CMD_STOP;
              w_state_nxt = S_STOP;
            end else begin
              w_cmd_nxt         = c_CMD_NONE;
              w_wdata_ready_nxt = 1'b1;
              w_state_nxt       = S_WDAT;
            end
          end
        end

        S_WDAT: begin
          // Two phases share this state: waiting for a data word
          // (wdata_ready high, no command) and the write in flight.
          if (r_wdata_ready) begin
            if (i_wdata_valid) begin
              w_wdata_ready_nxt = 1'b0;
              w_din_nxt         = i_wdata;
              w_cmd_nxt         = w_last ? c_CMD_WR_STOP : c_CMD_WR;
            end
          end else if (i_bc_cmd_ack) begin
            if (w_last) begin
              // STOP went out with this byte, so finish directly
              w_nack_nxt  = i_bc_ack_out;
              w_cmd_nxt   = c_CMD_NONE;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_DONE;
            end else if (i_bc_ack_out) begin
              w_nack_nxt  = 1'b1;
              w_cmd_nxt   = c_CMD_STOP;
              w_state_nxt = S_STOP;
            end else begin
              w_cnt_nxt         = w_cnt_inc;
              w_cmd_nxt         = c_CMD_NONE;
              w_wdata_ready_nxt = 1'b1;
            end
          end
        end

        S_RSTRT: begin
          if (i_bc_cmd_ack) begin
            if (i_bc_ack_out) begin
              w_nack_nxt  = 1'b1;
              w_cmd_nxt   = c_CMD_STOP;
              w_state_nxt = S_STOP;
            end else if (r_len == 4'd0) begin
              w_cmd_nxt   = c_CMD_STOP;
              w_state_nxt = S_STOP;
            end else begin
              w_cmd_nxt   = (r_len == 4'd1) ? c_CMD_RD_LAST : c_CMD_RD;
              w_state_nxt = S_RDAT;
            end
          end
        end

        S_RDAT: begin
          if (i_bc_cmd_ack) begin
            w_rdata_nxt       = i_bc_dout;
            w_rdata_valid_nxt = 1'b1;
            w_cmd_nxt         = c_CMD_NONE;
            w_state_nxt       = S_RHOLD;
          end
        end

        S_RHOLD: begin
          // Next read is only issued once the current byte is consumed,
          // so the consumer provides the back-pressure on the bus.
          if (i_rdata_ready) begin
            w_rdata_valid_nxt = 1'b0;
            if (w_last) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
              w_cmd_nxt   = w_last_inc ? c_CMD_RD_LAST : c_CMD_RD;
              w_state_nxt = S_RDAT;
            end
          end
        end

        S_STOP: begin
          if (i_bc_cmd_ack) begin
            w_cmd_nxt   = c_CMD_NONE;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end

        S_DONE: begin
          w_state_nxt = S_IDLE;
        end

        default: begin
          w_cmd_nxt         = c_CMD_NONE;
          w_wdata_ready_nxt = 1'b0;
          w_rdata_valid_nxt = 1'b0;
          w_state_nxt       = S_IDLE;
        end
      endcase
    end

    w_req_ready_nxt = (w_state_nxt == S_IDLE);
  end

  assign o_req_ready   = r_req_ready;
  assign o_wdata_ready = r_wdata_ready;
  assign o_rdata_valid = r_rdata_valid;
  assign o_rdata       = r_rdata;
  assign o_done        = r_done;
  assign o_nack        = r_nack;
  assign o_al_err      = r_al_err;
  assign o_bc_start    = r_cmd[4];
  assign o_bc_stop     = r_cmd[3];
  assign o_bc_read     = r_cmd[2];
  assign o_bc_write    = r_cmd[1];
  assign o_bc_ack_in   = r_cmd[0];
  assign o_bc_din      = r_din;

endmodule
`default_nettype wire

// File: tb/tb_ux607_i2c_master_txn_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ux607_i2c_master_txn_seq
// Purpose  : Self-checking bench for ux607_i2c_master_txn_seq. The bench acts
//            as byte controller, data producer and data consumer, and checks
//            the issued command list, read data and status against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ux607_i2c_master_txn_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [6:0] i_req_dev;
  logic       i_req_rnw;
  logic [7:0] i_req_reg;
  logic [3:0] i_req_len;
  logic       i_req_noreg;
  logic       i_wdata_valid;
  logic       o_wdata_ready;
  logic [7:0] i_wdata;
  logic       o_rdata_valid;
  logic       i_rdata_ready;
  logic [7:0] o_rdata;
  logic       o_done, o_nack, o_al_err;
  logic       o_bc_start, o_bc_stop, o_bc_read, o_bc_write, o_bc_ack_in;
  logic [7:0] o_bc_din;
  logic       i_bc_cmd_ack, i_bc_ack_out, i_bc_al;
  logic [7:0] i_bc_dout;

  always #5 clk = ~clk;

  ux607_i2c_master_txn_seq u_dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_dev     (i_req_dev),
    .i_req_rnw     (i_req_rnw),
    .i_req_reg     (i_req_reg),
    .i_req_len     (i_req_len),
`ifdef UX607_I2C_SEQ_NOREG_EN
    .i_req_noreg   (i_req_noreg),
`endif
    .i_wdata_valid (i_wdata_valid),
    .o_wdata_ready (o_wdata_ready),
    .i_wdata       (i_wdata),
    .o_rdata_valid (o_rdata_valid),
    .i_rdata_ready (i_rdata_ready),
    .o_rdata       (o_rdata),
    .o_done        (o_done),
    .o_nack        (o_nack),
    .o_al_err      (o_al_err),
    .o_bc_start    (o_bc_start),
    .o_bc_stop     (o_bc_stop),
    .o_bc_read     (o_bc_read),
    .o_bc_write    (o_bc_write),
    .o_bc_ack_in   (o_bc_ack_in),
    .o_bc_din      (o_bc_din),
    .i_bc_cmd_ack  (i_bc_cmd_ack),
    .i_bc_ack_out  (i_bc_ack_out),
    .i_bc_al       (i_bc_al),
    .i_bc_dout     (i_bc_dout)
  );

  // Command combinations named by what they do on the bus,
  // bit order {start, stop, read, write, ack_in}
  localparam logic [4:0] K_START_ADDR = 5'b10010;
  localparam logic [4:0] K_WRITE      = 5'b00010;
  localparam logic [4:0] K_WRITE_STOP = 5'b01010;
  localparam logic [4:0] K_READ_ACK   = 5'b00100;
  localparam logic [4:0] K_READ_LAST  = 5'b01101;
  localparam logic [4:0] K_STOP       = 5'b01000;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: builds the full command list a transaction should
  // produce from the bus-protocol rules, then cuts it at arbitration loss.
  // --------------------------------------------------------------------------
  logic [7:0] wd_a [16];
  logic [7:0] rd_a [16];
  logic [4:0] f_cmd [$];
  logic [7:0] f_din [$];
  bit         f_nk  [$];
  bit         f_rd  [$];
  bit         f_wd  [$];
  logic [7:0] exp_rd [$];
  int         exp_ncmd;
  int         exp_nwd;
  bit         exp_nack;
  bit         exp_al;

  task automatic mpush(input logic [4:0] c, input logic [7:0] d, input bit is_rd, input bit is_wd);
    f_cmd.push_back(c);
    f_din.push_back(d);
    f_nk.push_back(1'b0);
    f_rd.push_back(is_rd);
    f_wd.push_back(is_wd);
  endtask

  // Is the command just pushed the one the slave NACKs?
  task automatic mnak(input int nack_pos, output bit nk);
    nk = ((f_cmd.size() - 1) == nack_pos);
    if (nk) f_nk[f_cmd.size() - 1] = 1'b1;
  endtask

  task automatic build_model(input logic [6:0] dev, input bit rnw, input logic [7:0] rg,
                             input int len, input bit noreg, input int nack_pos, input int al_pos);
    bit fin;
    bit nk;
    int n;
    int ri;
    f_cmd.delete(); f_din.delete(); f_nk.delete(); f_rd.delete(); f_wd.delete();
    exp_rd.delete();
    fin = 1'b0;
    if (!(noreg && rnw)) begin
      mpush(K_START_ADDR, {dev, 1'b0}, 0, 0);
      mnak(nack_pos, nk);
      if (nk) begin mpush(K_STOP, 8'h00, 0, 0); fin = 1'b1; end
    end
    if (!fin && !noreg) begin
      mpush(K_WRITE, rg, 0, 0);
      mnak(nack_pos, nk);
      if (nk) begin mpush(K_STOP, 8'h00, 0, 0); fin = 1'b1; end
    end
    if (!fin) begin
      if (rnw) begin
        mpush(K_START_ADDR, {dev, 1'b1}, 0, 0);
        mnak(nack_pos, nk);
        if (nk || len == 0) mpush(K_STOP, 8'h00, 0, 0);
        else for (int i = 0; i < len; i++)
          mpush((i == len - 1) ? K_READ_LAST : K_READ_ACK, 8'h00, 1, 0);
      end else begin
        if (len == 0) mpush(K_STOP, 8'h00, 0, 0);
        else for (int i = 0; i < len; i++) begin
          mpush((i == len - 1) ? K_WRITE_STOP : K_WRITE, wd_a[i], 0, 1);
          mnak(nack_pos, nk);
          if (nk) begin
            if (i != len - 1) mpush(K_STOP, 8'h00, 0, 0);
            break;
          end
        end
      end
    end
    exp_al   = (al_pos >= 0) && (al_pos < f_cmd.size());
    n        = exp_al ? al_pos + 1 : f_cmd.size();
    exp_ncmd = n;
    exp_nwd  = 0;
    exp_nack = 1'b0;
    ri       = 0;
    for (int i = 0; i < n; i++) begin
      if (f_wd[i]) exp_nwd++;
      // the command hit by arbitration loss never completes
      if (!(exp_al && i == al_pos)) begin
        if (f_nk[i]) exp_nack = 1'b1;
        if (f_rd[i]) begin exp_rd.push_back(rd_a[ri]); ri++; end
      end
    end
  endtask

  function automatic logic [4:0] cmd_now();
    return {o_bc_start, o_bc_stop, o_bc_read, o_bc_write, o_bc_ack_in};
  endfunction

  function automatic logic [31:0] outs_now();
    return {5'd0, o_req_ready, o_wdata_ready, o_rdata_valid, o_rdata, o_done,
            o_nack, o_al_err, cmd_now(), o_bc_din};
  endfunction

  // --------------------------------------------------------------------------
  // One transaction: bench plays byte controller, data source and sink.
  // --------------------------------------------------------------------------
  task automatic run_txn(input string nm, input logic [6:0] dev, input bit rnw,
                         input logic [7:0] rg, input int len, input bit noreg,
                         input int nack_pos, input int al_pos, input int rd_wait,
                         input bit rst_mid);
    logic [4:0] g_cmd [$];
    logic [7:0] g_din [$];
    logic [7:0] g_rd  [$];
    logic [4:0] cmd, pc;
    logic [7:0] pd;
    int   wait_cnt, rd_hold, wi, rgi, viol, ci, cyc;
    bit   got_done, saw_wr, al_last, acked, wd_pend, rd_pend, first;
    bit   d_nack, d_al;

    build_model(dev, rnw, rg, len, noreg, nack_pos, al_pos);
    wait_cnt = $urandom_range(0, 3);
    rd_hold = rd_wait; wi = 0; rgi = 0; viol = 0;
    got_done = 0; saw_wr = 0; al_last = 0; acked = 0; wd_pend = 0; rd_pend = 0;
    first = 1; pc = 5'd0; pd = 8'd0; d_nack = 0; d_al = 0;

    cyc = 0;
    while (!o_req_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk($sformatf("%s:req_ready", nm), {31'd0, o_req_ready}, 32'd1);
    i_req_dev = dev; i_req_rnw = rnw; i_req_reg = rg; i_req_len = 4'(len);
    i_req_noreg = noreg; i_req_valid = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      i_req_valid = 1'b0; i_bc_cmd_ack = 1'b0; i_bc_al = 1'b0; i_bc_ack_out = 1'b0;
      i_wdata_valid = 1'b0; i_rdata_ready = 1'b0;
      cmd = cmd_now();
      if (first) begin
        chk($sformatf("%s:busy_status", nm), {29'd0, o_req_ready, o_nack, o_al_err}, 32'd0);
        first = 0;
      end
      if (wd_pend) begin wi++; wd_pend = 0; end
      if (rd_pend) begin rd_pend = 0; rd_hold = rd_wait; end
      if (al_last) begin
        chk($sformatf("%s:al_clear", nm), {25'd0, cmd, o_wdata_ready, o_rdata_valid}, 32'd0);
        al_last = 0;
      end
      if (pc != 5'd0 && !acked && (cmd != pc || o_bc_din != pd)) viol++;
      if ((o_wdata_ready || o_rdata_valid || o_done || o_req_ready) && cmd != 5'd0) viol++;
      pc = cmd; pd = o_bc_din; acked = 0;
      if (o_done) begin
        got_done = 1; d_nack = o_nack; d_al = o_al_err;
        break;
      end
      if (rst_mid && cmd[2]) begin
        #2 rst = 1'b1;
        #1 chk($sformatf("%s:rst_outs", nm), outs_now(), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("%s:rst_hold", nm), {31'd0, o_req_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s:rst_rdy", nm), {31'd0, o_req_ready}, 32'd1);
        return;
      end
      if (o_wdata_ready) begin
        saw_wr = 1;
        if ($urandom_range(0, 2) == 0) begin
          i_wdata_valid = 1'b1; i_wdata = wd_a[wi]; wd_pend = 1;
        end
      end
      if (o_rdata_valid) begin
        if (rd_hold > 0) rd_hold--;
        else begin i_rdata_ready = 1'b1; g_rd.push_back(o_rdata); rd_pend = 1; end
      end
      if (cmd != 5'd0) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          ci = g_cmd.size();
          g_cmd.push_back(cmd); g_din.push_back(o_bc_din);
          acked = 1; wait_cnt = $urandom_range(0, 3);
          if (ci == al_pos) begin
            i_bc_al = 1'b1; i_bc_cmd_ack = 1'($urandom_range(0, 1)); al_last = 1;
          end else begin
            i_bc_cmd_ack = 1'b1;
            i_bc_ack_out = (ci == nack_pos);
            if (cmd[2]) begin i_bc_dout = rd_a[rgi]; rgi++; end
            else i_bc_dout = 8'($urandom);
          end
        end
      end
    end

    chk($sformatf("%s:done_seen", nm), {31'd0, got_done}, 32'd1);
    chk($sformatf("%s:ncmd", nm), g_cmd.size(), exp_ncmd);
    for (int i = 0; i < exp_ncmd && i < g_cmd.size(); i++) begin
      chk($sformatf("%s:cmd%0d", nm, i), {27'd0, g_cmd[i]}, {27'd0, f_cmd[i]});
      if (f_cmd[i][1]) chk($sformatf("%s:din%0d", nm, i), {24'd0, g_din[i]}, {24'd0, f_din[i]});
    end
    chk($sformatf("%s:nrd", nm), g_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < g_rd.size(); i++)
      chk($sformatf("%s:rd%0d", nm, i), {24'd0, g_rd[i]}, {24'd0, exp_rd[i]});
    chk($sformatf("%s:nack", nm), {31'd0, d_nack}, {31'd0, exp_nack});
    chk($sformatf("%s:al_err", nm), {31'd0, d_al}, {31'd0, exp_al});
    chk($sformatf("%s:nwdata", nm), wi, exp_nwd);
    chk($sformatf("%s:wready_seen", nm), {31'd0, saw_wr}, {31'd0, exp_nwd > 0});
    chk($sformatf("%s:protocol", nm), viol, 0);
    @(posedge clk); #1;
    chk($sformatf("%s:after_done", nm), {29'd0, o_done, o_req_ready, |cmd_now()}, 32'd2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, ap, ln;
    bit nr;
    rst = 1'b1;
    i_req_valid = 0; i_req_dev = 0; i_req_rnw = 0; i_req_reg = 0; i_req_len = 0;
    i_req_noreg = 0; i_wdata_valid = 0; i_wdata = 0; i_rdata_ready = 0;
    i_bc_cmd_ack = 0; i_bc_ack_out = 0; i_bc_al = 0; i_bc_dout = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs_now(), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_rdy", {31'd0, o_req_ready}, 32'd1);

    // Directed scenarios
    wd_a[0] = 8'hA5; wd_a[1] = 8'h3C;
    run_txn("wr2", 7'h50, 0, 8'h10, 2, 0, -1, -1, 1, 0);
    rd_a[0] = 8'h11; rd_a[1] = 8'h22; rd_a[2] = 8'h33;
    run_txn("rd3", 7'h50, 1, 8'h02, 3, 0, -1, -1, 2, 0);
    run_txn("devnak", 7'h50, 0, 8'h10, 2, 0, 0, -1, 0, 0);
    run_txn("al_wr2", 7'h50, 0, 8'h10, 2, 0, -1, 3, 0, 0);
    run_txn("rdhold", 7'h50, 1, 8'h02, 2, 0, -1, -1, 20, 0);
    run_txn("wr0", 7'h2A, 0, 8'h7F, 0, 0, -1, -1, 0, 0);
    run_txn("rst_mid", 7'h50, 1, 8'h02, 3, 0, -1, -1, 1, 1);
`ifdef UX607_I2C_SEQ_NOREG_EN
    rd_a[0] = 8'h5A;
    run_txn("noreg_rd", 7'h50, 1, 8'h00, 1, 1, -1, -1, 0, 0);
`endif

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) begin
        wd_a[i] = 8'($urandom);
        rd_a[i] = 8'($urandom);
      end
      ln = $urandom_range(0, 15);
      np = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1;
      ap = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : -1;
`ifdef UX607_I2C_SEQ_NOREG_EN
      nr = 1'($urandom_range(0, 1));
`else
      nr = 1'b0;
`endif
      run_txn($sformatf("rnd%0d", t), 7'($urandom), 1'($urandom_range(0, 1)),
              8'($urandom), ln, nr, np, ap, $urandom_range(0, 3), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
